// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master data-memory arbiter.
// Holds the FSM encoding, the word width and an alignment helper.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic is_aligned(input word_t a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: contention goes to the master not granted last.
// A sole requester always wins; grant is the index of the winner.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one data-memory port with a fixed number
// of wait states per access; misaligned requests complete with err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [WORD_W-1:0] m0_addr,
    input  logic [WORD_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [WORD_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [WORD_W-1:0] m1_addr,
    input  logic [WORD_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [WORD_W-1:0] m1_rdata,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       gnt_q, gnt_d;
    logic       we_q, we_d;
    logic       err_q, err_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    word_t      rdata0_q, rdata0_d;
    word_t      rdata1_q, rdata1_d;

    logic       sel;
    logic       sel_we;
    word_t      sel_addr;
    word_t      sel_wdata;
    logic       in_access;
    logic       in_done;

    rr_arbiter2 u_rr (
        .req   ({m1_req, m0_req}),
        .last  (last_q),
        .grant (sel)
    );

    always_comb begin
        sel_we    = sel ? m1_we    : m0_we;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_wdata = sel ? m1_wdata : m0_wdata;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d  = sel;
                    last_d = sel;
                    if (is_aligned(sel_addr)) begin
                        we_d    = sel_we;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        err_d   = 1'b0;
                        cnt_d   = CNT_INIT;
                        state_d = ST_ACCESS;
                    end else begin
                        // Misaligned: bypass memory, report err on ack.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    if (!we_q && !gnt_q) rdata0_d = mem_rdata;
                    if (!we_q &&  gnt_q) rdata1_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign in_done   = (state_q == ST_DONE);

    assign mem_read  = in_access && !we_q;
    assign mem_write = in_access && we_q && (cnt_q == 4'd0);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign m0_ack   = in_done && !gnt_q;
    assign m1_ack   = in_done &&  gnt_q;
    assign m0_err   = m0_ack && err_q;
    assign m1_err   = m1_ack && err_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized two-master run against a transaction-level model.
module tb_mem_arbiter;

    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic        w0_m0_ack, w0_m0_err, w0_m1_ack, w0_m1_err;
    logic [31:0] w0_m0_rdata, w0_m1_rdata, w0_mem_addr, w0_mem_wdata;
    logic        w0_mem_read, w0_mem_write;
    logic        w15_m0_ack, w15_m0_err, w15_m1_ack, w15_m1_err;
    logic [31:0] w15_m0_rdata, w15_m1_rdata, w15_mem_addr, w15_mem_wdata;
    logic        w15_mem_read, w15_mem_write;
    logic [31:0] xmem_rdata;
    assign xmem_rdata = 32'hA5A5_0000;

    logic [31:0] tbmem [0:63] = '{default: 32'h0};
    assign mem_rdata = tbmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) tbmem[mem_addr[7:2]] <= mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(w0_m0_ack), .m0_err(w0_m0_err), .m0_rdata(w0_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(w0_m1_ack), .m1_err(w0_m1_err), .m1_rdata(w0_m1_rdata),
        .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata),
        .mem_read(w0_mem_read), .mem_write(w0_mem_write), .mem_rdata(xmem_rdata)
    );

    mem_arbiter #(.WAIT_STATES(15)) u_ws15 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(w15_m0_ack), .m0_err(w15_m0_err), .m0_rdata(w15_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(w15_m1_ack), .m1_err(w15_m1_err), .m1_rdata(w15_m1_rdata),
        .mem_addr(w15_mem_addr), .mem_wdata(w15_mem_wdata),
        .mem_read(w15_mem_read), .mem_write(w15_mem_write), .mem_rdata(xmem_rdata)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        @(negedge clk);
        m0_req = 1'b1;
        m1_req = 1'b1;
        rst = 1'b1;
        #1;
        for (int r = 0; r < 2; r++) begin
            ctl = {m0_ack, m1_ack, m0_err, m1_err, mem_read, mem_write};
            checks++;
            if (ctl !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctl got=%b exp=000000", ctl);
            end
            checks++;
            if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
                errors++;
                $display("FAIL reset_data got=%h %h %h %h exp=0",
                         mem_addr, mem_wdata, m0_rdata, m1_rdata);
            end
            checks++;
            if ({w0_m0_ack, w0_m1_ack, w0_m0_err, w0_m1_err, w0_mem_read,
                 w0_mem_write, w0_mem_addr, w0_mem_wdata, w0_m0_rdata,
                 w0_m1_rdata} !== 134'h0) begin
                errors++;
                $display("FAIL reset_ws0 got=nonzero exp=0");
            end
            checks++;
            if ({w15_m0_ack, w15_m1_ack, w15_m0_err, w15_m1_err, w15_mem_read,
                 w15_mem_write, w15_mem_addr, w15_mem_wdata, w15_m0_rdata,
                 w15_m1_rdata} !== 134'h0) begin
                errors++;
                $display("FAIL reset_ws15 got=nonzero exp=0");
            end
            @(negedge clk);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int t0, wr_cnt, wr_at, ack_at, rd_cnt;
        logic [31:0] rdv;
        @(negedge clk);
        m0_we = 1'b1;
        m0_addr = 32'h10;
        m0_wdata = 32'hDEAD_BEEF;
        m0_req = 1'b1;
        t0 = cyc;
        wr_cnt = 0;
        wr_at = -1;
        ack_at = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_write) begin
                wr_cnt++;
                wr_at = cyc - t0;
            end
            if (m0_ack && ack_at < 0) begin
                ack_at = cyc - t0;
                m0_req = 1'b0;
            end
        end
        m0_req = 1'b0;
        checks++;
        if (wr_cnt !== 1 || wr_at !== 2) begin
            errors++;
            $display("FAIL wr_pulse got=%0d@%0d exp=1@2", wr_cnt, wr_at);
        end
        checks++;
        if (ack_at !== 3) begin
            errors++;
            $display("FAIL wr_ack_lat got=%0d exp=3", ack_at);
        end
        checks++;
        if (tbmem[4] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_mem got=%h exp=deadbeef", tbmem[4]);
        end
        m1_we = 1'b0;
        m1_addr = 32'h10;
        m1_req = 1'b1;
        t0 = cyc;
        rd_cnt = 0;
        ack_at = -1;
        rdv = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_read) rd_cnt++;
            if (m0_ack) ack_at = -99;
            if (m1_ack && ack_at == -1) begin
                ack_at = cyc - t0;
                rdv = m1_rdata;
                m1_req = 1'b0;
            end
        end
        m1_req = 1'b0;
        checks++;
        if (rd_cnt !== 2) begin
            errors++;
            $display("FAIL rd_cycles got=%0d exp=2", rd_cnt);
        end
        checks++;
        if (ack_at !== 3 || rdv !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_ack got=%0d/%h exp=3/deadbeef", ack_at, rdv);
        end
    endtask

    task automatic test_misaligned();
        int t0, ack_at, mem_hits, other;
        logic err_v;
        @(negedge clk);
        m0_we = 1'b1;
        m0_addr = 32'h13;
        m0_req = 1'b1;
        t0 = cyc;
        ack_at = -1;
        mem_hits = 0;
        other = 0;
        err_v = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_read || mem_write) mem_hits++;
            if (m1_ack || m1_err) other++;
            if (m0_ack && ack_at < 0) begin
                ack_at = cyc - t0;
                err_v = m0_err;
                m0_req = 1'b0;
            end
        end
        m0_req = 1'b0;
        checks++;
        if (ack_at !== 1 || err_v !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_ack got=%0d/err%b exp=1/err1", ack_at, err_v);
        end
        checks++;
        if (mem_hits !== 0 || other !== 0) begin
            errors++;
            $display("FAIL misaligned_mem got=%0d/%0d exp=0/0", mem_hits, other);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] pre;
        int bad, first;
        pre = tbmem[8];
        @(negedge clk);
        m0_we = 1'b1;
        m0_addr = 32'h20;
        m0_wdata = ~pre;
        m0_req = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        checks++;
        if ({m0_ack, m1_ack, mem_read, mem_write} !== 4'b0) begin
            errors++;
            $display("FAIL abort_now got=%b exp=0000",
                     {m0_ack, m1_ack, mem_read, mem_write});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack || mem_write) bad++;
        end
        checks++;
        if (bad !== 0 || tbmem[8] !== pre) begin
            errors++;
            $display("FAIL abort_quiet got=%0d/%h exp=0/%h", bad, tbmem[8], pre);
        end
        m0_we = 1'b0;
        m1_we = 1'b0;
        m0_addr = 32'h10;
        m1_addr = 32'h10;
        m0_req = 1'b1;
        m1_req = 1'b1;
        first = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (first < 0 && (m0_ack || m1_ack)) first = m1_ack ? 1 : 0;
            if (m0_ack) m0_req = 1'b0;
            if (m1_ack) m1_req = 1'b0;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        checks++;
        if (first !== 0) begin
            errors++;
            $display("FAIL abort_regrant got=m%0d exp=m0", first);
        end
    endtask

    task automatic test_latency();
        int t0, l1, l0, l15, wr;
        logic [31:0] r0, r15;
        do_reset();
        m0_we = 1'b0;
        m0_addr = 32'h0;
        m0_req = 1'b1;
        t0 = cyc;
        l1 = -1;
        l0 = -1;
        l15 = -1;
        wr = 0;
        r0 = 0;
        r15 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (m0_ack && l1 < 0) l1 = cyc - t0;
            if (w0_m0_ack && l0 < 0) begin
                l0 = cyc - t0;
                r0 = w0_m0_rdata;
            end
            if (w15_m0_ack && l15 < 0) begin
                l15 = cyc - t0;
                r15 = w15_m0_rdata;
            end
            if (w0_mem_write || w15_mem_write) wr++;
        end
        m0_req = 1'b0;
        checks++;
        if (l0 !== 2 || l1 !== 3 || l15 !== 17) begin
            errors++;
            $display("FAIL latency got=%0d/%0d/%0d exp=2/3/17", l0, l1, l15);
        end
        checks++;
        if (r0 !== xmem_rdata || r15 !== xmem_rdata || wr !== 0) begin
            errors++;
            $display("FAIL latency_data got=%h/%h/%0d exp=%h/%h/0",
                     r0, r15, wr, xmem_rdata, xmem_rdata);
        end
        do_reset();
    endtask

    // Transaction-level model: a grant at cycle t completes at t+WS+2
    // (t+1 if misaligned); the next grant may happen the cycle after.
    task automatic test_random(input int ncyc, input bit both, input bit drop);
        logic [31:0] ref_mem [0:63];
        logic [31:0] last_rd [2];
        logic [31:0] p_addr [2];
        logic [31:0] p_wdata [2];
        logic [31:0] rd [2];
        logic        p_req [2];
        logic        p_we [2];
        int          status [2];
        int          last, t0, next_s, n, w, done_c, prev_who, who;
        bit          active, cwe, cmis, in_acc, e_rd, e_wr, e_done;
        int          cm;
        logic [31:0] caddr, cwdata, exp_rd;
        logic [5:0]  e_ctl, g_ctl;
        for (int i = 0; i < 64; i++) ref_mem[i] = tbmem[i];
        for (int i = 0; i < 2; i++) begin
            last_rd[i] = 32'h0;
            p_req[i] = 1'b0;
            p_we[i] = 1'b0;
            p_addr[i] = 32'h0;
            p_wdata[i] = 32'h0;
            status[i] = 0;
        end
        last = 1;
        active = 0;
        prev_who = 1;
        t0 = 0;
        cm = 0;
        cwe = 0;
        cmis = 0;
        caddr = 0;
        cwdata = 0;
        @(negedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        next_s = cyc;
        for (int it = 0; it < ncyc; it++) begin
            if (it > 0) @(negedge clk);
            n = cyc;
            done_c = cmis ? t0 + 1 : t0 + WS + 2;
            in_acc = active && !cmis && n > t0 && n <= t0 + WS + 1;
            e_rd = in_acc && !cwe;
            e_wr = in_acc && cwe && n == t0 + WS + 1;
            e_done = active && n == done_c;
            e_ctl = {e_done && cm == 0, e_done && cm == 1,
                     e_done && cm == 0 && cmis, e_done && cm == 1 && cmis,
                     e_rd, e_wr};
            g_ctl = {m0_ack, m1_ack, m0_err, m1_err, mem_read, mem_write};
            checks++;
            if (g_ctl !== e_ctl) begin
                errors++;
                $display("FAIL ctl cyc=%0d got=%b exp=%b", n, g_ctl, e_ctl);
            end
            if (in_acc) begin
                checks++;
                if (mem_addr !== caddr || (cwe && mem_wdata !== cwdata)) begin
                    errors++;
                    $display("FAIL bus cyc=%0d got=%h/%h exp=%h/%h",
                             n, mem_addr, mem_wdata, caddr, cwdata);
                end
            end
            rd[0] = m0_rdata;
            rd[1] = m1_rdata;
            for (int i = 0; i < 2; i++) begin
                if (e_done && cm == i && !cwe && !cmis)
                    last_rd[i] = ref_mem[caddr[7:2]];
                exp_rd = last_rd[i];
                checks++;
                if (rd[i] !== exp_rd) begin
                    errors++;
                    $display("FAIL rdata%0d cyc=%0d got=%h exp=%h",
                             i, n, rd[i], exp_rd);
                end
            end
            if (both && (m0_ack || m1_ack)) begin
                who = m1_ack ? 1 : 0;
                checks++;
                if (who === prev_who) begin
                    errors++;
                    $display("FAIL rr_alt cyc=%0d got=m%0d exp=m%0d",
                             n, who, 1 - prev_who);
                end
                prev_who = who;
            end
            if (e_done) begin
                if (cwe && !cmis) ref_mem[caddr[7:2]] = cwdata;
                active = 0;
                next_s = n + 1;
                status[cm] = 0;
                p_req[cm] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (status[i] == 0 && (both || $urandom_range(0, 2) == 0)) begin
                    p_we[i] = 1'($urandom_range(0, 1));
                    p_addr[i] = 32'($urandom_range(0, 15)) << 2;
                    if ($urandom_range(0, 7) == 0)
                        p_addr[i] = p_addr[i] + 32'($urandom_range(1, 3));
                    p_wdata[i] = $urandom;
                    p_req[i] = 1'b1;
                    status[i] = 1;
                end else if (drop && status[i] == 2 && $urandom_range(0, 3) == 0) begin
                    p_req[i] = 1'b0;
                end
            end
            m0_req = p_req[0];
            m0_we = p_we[0];
            m0_addr = p_addr[0];
            m0_wdata = p_wdata[0];
            m1_req = p_req[1];
            m1_we = p_we[1];
            m1_addr = p_addr[1];
            m1_wdata = p_wdata[1];
            if (!active && n >= next_s && (p_req[0] || p_req[1])) begin
                w = (p_req[0] && p_req[1]) ? 1 - last : (p_req[1] ? 1 : 0);
                last = w;
                active = 1;
                t0 = n;
                cm = w;
                cwe = p_we[w];
                caddr = p_addr[w];
                cwdata = p_wdata[w];
                cmis = caddr[1:0] != 2'b00;
                status[w] = 2;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_reset_mid_access();
        test_random(400, 1'b0, 1'b1);
        test_random(80, 1'b1, 1'b0);
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
